// File: rtl/instr_fetch_unit_if.sv
// Fetch stage bundle: imem request/response, redirect input and the decode-side
// instruction handshake.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic        misalign_err;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        output instr_pc_plus4,
        output misalign_err
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        input  instr_pc_plus4,
        input  misalign_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps one imem request outstanding and buffers
// returned words in a 2-entry queue towards decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } qent_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    qent_t       q [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        mis_q;
    logic        redir, inflight, acc, push, pop;
    logic [2:0]  credit;

    assign redir    = bus.redirect_valid;
    assign inflight = (state == WAIT) || (state == DROP);
    assign credit   = {1'b0, count} + {2'b00, inflight};

    assign bus.imem_req_valid = (state == REQ) && (credit < 3'd2);
    assign bus.imem_req_addr  = {fetch_pc[31:2], 2'b00};
    assign acc  = bus.imem_req_valid && bus.imem_req_ready;
    // A response racing a redirect belongs to the old path and is discarded.
    assign push = (state == WAIT) && bus.imem_rsp_valid && !redir;

    assign bus.instr_valid    = (count != 2'd0);
    assign pop                = bus.instr_valid && bus.instr_ready;
    assign bus.instr          = bus.instr_valid ? q[rd_ptr].data : NOP_WORD;
    assign bus.instr_pc       = bus.instr_valid ? q[rd_ptr].pc : 32'h0;
    assign bus.instr_pc_plus4 = bus.instr_pc + 32'd4;
    assign bus.misalign_err   = mis_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (acc) state_nxt = redir ? DROP : WAIT;
            end
            WAIT: begin
                if (bus.imem_rsp_valid) state_nxt = REQ;
                else if (redir)         state_nxt = DROP;
            end
            DROP: begin
                if (bus.imem_rsp_valid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            mis_q <= redir && (bus.redirect_pc[1:0] != 2'b00);
            if (redir)    fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            else if (acc) fetch_pc <= fetch_pc + 32'd4;
            if (acc)      req_pc <= {fetch_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            q[0]   <= '0;
            q[1]   <= '0;
        end else if (redir) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                q[wr_ptr] <= '{data: bus.imem_rsp_data, pc: req_pc};
                wr_ptr    <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (!push && pop) count <= count - 2'd1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: an imem model with random latency plus a
// path-level reference (expected PC stream, queue occupancy, drop tracking).
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_unit_if bus ();

    instr_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc;
    bit pend, pend_stale, started, mis_exp;
    logic [31:0] pend_addr, fpc, exp_pc;
    int pend_wait, qcount, lat_min, lat_max;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_ins[$];
    logic [31:0] pop_p4[$];

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 0; pend_stale = 0; started = 0; mis_exp = 0;
        fpc = 32'h0; exp_pc = 32'h0; qcount = 0; cyc = 0;
        acc_addr.delete(); acc_cyc.delete();
        pop_pc.delete(); pop_ins.delete(); pop_p4.delete();
    endtask

    // One clock: drive imem response, check against the model at negedge,
    // then advance the model after the rising edge.
    task automatic tick();
        logic acc, rsp, pop, push, rd, exp_rv;
        logic [31:0] rpc, addr;
        int nq;
        if (pend && pend_wait == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pend_addr | 32'h13;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        rd   = bus.redirect_valid;
        rpc  = bus.redirect_pc;
        addr = bus.imem_req_addr;
        acc  = bus.imem_req_valid & bus.imem_req_ready;
        rsp  = bus.imem_rsp_valid;
        pop  = bus.instr_valid & bus.instr_ready;
        exp_rv = started && !pend && (qcount < 2);
        checks++;
        if (bus.imem_req_valid !== exp_rv) begin
            errors++;
            $display("FAIL req_valid cyc %0d got %b exp %b", cyc, bus.imem_req_valid, exp_rv);
        end
        if (exp_rv) begin
            checks++;
            if (addr !== fpc) begin
                errors++;
                $display("FAIL req_addr cyc %0d got %h exp %h", cyc, addr, fpc);
            end
        end
        checks++;
        if (bus.instr_valid !== (qcount != 0)) begin
            errors++;
            $display("FAIL instr_valid cyc %0d got %b exp %b", cyc, bus.instr_valid, qcount != 0);
        end
        checks++;
        if (bus.misalign_err !== mis_exp) begin
            errors++;
            $display("FAIL misalign cyc %0d got %b exp %b", cyc, bus.misalign_err, mis_exp);
        end
        if (pop) begin
            checks++;
            if (bus.instr_pc !== exp_pc || bus.instr !== (exp_pc | 32'h13) ||
                bus.instr_pc_plus4 !== exp_pc + 32'd4) begin
                errors++;
                $display("FAIL deliver cyc %0d got pc %h ins %h p4 %h exp pc %h",
                         cyc, bus.instr_pc, bus.instr, bus.instr_pc_plus4, exp_pc);
            end
            pop_pc.push_back(bus.instr_pc);
            pop_ins.push_back(bus.instr);
            pop_p4.push_back(bus.instr_pc_plus4);
            exp_pc = exp_pc + 32'd4;
        end else if (!bus.instr_valid) begin
            checks++;
            if (bus.instr !== NOP || bus.instr_pc !== 32'h0) begin
                errors++;
                $display("FAIL empty_out cyc %0d got ins %h pc %h exp %h 0", cyc, bus.instr, bus.instr_pc, NOP);
            end
        end
        if (acc) begin
            acc_addr.push_back(addr);
            acc_cyc.push_back(cyc);
        end
        push = rsp && !pend_stale && !rd;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        mis_exp = rd && (rpc[1:0] != 2'b00);
        if (rd) begin
            qcount = 0;
            fpc    = {rpc[31:2], 2'b00};
            exp_pc = {rpc[31:2], 2'b00};
        end else begin
            nq = qcount + int'(push) - int'(pop);
            checks++;
            if (nq > 2) begin
                errors++;
                $display("FAIL overflow cyc %0d got %0d exp <=2", cyc, nq);
            end
            qcount = nq;
            if (acc) fpc = fpc + 32'd4;
        end
        if (rsp) pend = 0;
        else if (pend && pend_wait > 0) pend_wait--;
        if (rd && pend) pend_stale = 1;
        if (acc) begin
            pend       = 1;
            pend_addr  = addr;
            pend_stale = rd;
            pend_wait  = $urandom_range(lat_min, lat_max);
        end
        started = 1;
        cyc++;
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 60 && acc_addr.size() < n; i++) tick();
        checks++;
        if (acc_addr.size() < n) begin
            errors++;
            $display("FAIL acc_timeout got %0d exp %0d", acc_addr.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== NOP ||
            bus.instr_pc !== 32'h0 || bus.instr_pc_plus4 !== 32'h4 || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got rv %b iv %b ins %h pc %h mis %b exp 0 0 %h 0 0",
                     bus.imem_req_valid, bus.instr_valid, bus.instr, bus.instr_pc, bus.misalign_err, NOP);
        end
    endtask

    task automatic test_basic();
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_addr.size() <= i || acc_addr[i] !== 32'(4 * i) || acc_cyc[i] != 2 * i + 1) begin
                errors++;
                $display("FAIL basic_req%0d got %h@%0d exp %h@%0d", i,
                         acc_addr.size() > i ? acc_addr[i] : 32'hx,
                         acc_cyc.size() > i ? acc_cyc[i] : -1, 4 * i, 2 * i + 1);
            end
        end
        checks++;
        if (pop_pc.size() < 2 || pop_ins[0] !== 32'h13 || pop_pc[0] !== 32'h0 || pop_p4[0] !== 32'h4 ||
            pop_ins[1] !== 32'h17 || pop_pc[1] !== 32'h4 || pop_p4[1] !== 32'h8) begin
            errors++;
            $display("FAIL basic_deliver got %0d items exp (13,0,4),(17,4,8)", pop_pc.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        repeat (12) tick();
        checks++;
        if (acc_addr.size() != 2 || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got acc %0d rv %b iv %b exp 2 0 1",
                     acc_addr.size(), bus.imem_req_valid, bus.instr_valid);
        end
        bus.instr_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (pop_pc.size() < 3 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4 || pop_pc[2] !== 32'h8) begin
            errors++;
            $display("FAIL bp_order got %0d items exp pcs 0 4 8", pop_pc.size());
        end
        checks++;
        if (acc_addr.size() < 3 || acc_addr[2] !== 32'h8) begin
            errors++;
            $display("FAIL bp_resume got %h exp 00000008", acc_addr.size() > 2 ? acc_addr[2] : 32'hx);
        end
    endtask

    task automatic test_redirect_wait();
        int n;
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        wait_acc(3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_flush got %b exp 0", bus.instr_valid);
        end
        n = acc_addr.size();
        pop_pc.delete();
        wait_acc(n + 1);
        checks++;
        if (acc_addr.size() <= n || acc_addr[n] !== 32'h100) begin
            errors++;
            $display("FAIL rw_next_req got %h exp 00000100", acc_addr.size() > n ? acc_addr[n] : 32'hx);
        end
        repeat (4) tick();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'h100) begin
            errors++;
            $display("FAIL rw_first_pc got %h exp 00000100", pop_pc.size() > 0 ? pop_pc[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_acc();
        int n;
        bit hit;
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (bus.imem_req_valid === 1'b1 && bus.imem_req_addr === 32'hC) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h200;
                hit = 1;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL ra_timeout got none exp req 0000000c");
        end
        n = acc_addr.size();
        pop_pc.delete();
        wait_acc(n + 1);
        checks++;
        if (n == 0 || acc_addr.size() <= n || acc_addr[n - 1] !== 32'hC || acc_addr[n] !== 32'h200) begin
            errors++;
            $display("FAIL ra_next_req got %h exp 00000200", acc_addr.size() > n ? acc_addr[n] : 32'hx);
        end
        repeat (4) tick();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'h200) begin
            errors++;
            $display("FAIL ra_first_pc got %h exp 00000200", pop_pc.size() > 0 ? pop_pc[0] : 32'hx);
        end
    endtask

    task automatic test_misalign();
        int n;
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h202;
        tick();
        n = acc_addr.size();
        checks++;
        if (bus.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL mis_pulse got %b exp 1", bus.misalign_err);
        end
        tick();
        checks++;
        if (bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_width got %b exp 0", bus.misalign_err);
        end
        wait_acc(n + 1);
        checks++;
        if (acc_addr.size() <= n || acc_addr[n] !== 32'h200) begin
            errors++;
            $display("FAIL mis_req got %h exp 00000200", acc_addr.size() > n ? acc_addr[n] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        lat_min = 0; lat_max = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (4) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        n = acc_addr.size();
        pop_pc.delete(); pop_p4.delete();
        wait_acc(n + 2);
        checks++;
        if (acc_addr.size() < n + 2 || acc_addr[n] !== 32'hFFFF_FFFC || acc_addr[n + 1] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req got %h exp 00000000", acc_addr.size() > n + 1 ? acc_addr[n + 1] : 32'hx);
        end
        repeat (4) tick();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'hFFFF_FFFC || pop_p4[0] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_p4 got %h exp 00000000", pop_p4.size() > 0 ? pop_p4[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        lat_min = 4; lat_max = 4;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b0;
        wait_acc(2);
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL ar_pre got iv %b pc %h exp 1 0", bus.instr_valid, bus.instr_pc);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== NOP ||
            bus.instr_pc !== 32'h0 || bus.misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL ar_out got rv %b iv %b ins %h pc %h exp 0 0 %h 0",
                     bus.imem_req_valid, bus.instr_valid, bus.instr, bus.instr_pc, NOP);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 0; lat_max = 2;
        for (int i = 0; i < 600; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.instr_ready    = ($urandom_range(0, 2) != 0);
            if (i > 2 && $urandom_range(0, 19) == 0) begin
                bus.redirect_valid = 1'b1;
                if ($urandom_range(0, 5) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else                           bus.redirect_pc = $urandom & 32'h0000_0FFF;
            end
            tick();
        end
        checks++;
        if (pop_pc.size() < 50) begin
            errors++;
            $display("FAIL rand_progress got %0d exp >=50", pop_pc.size());
        end
    endtask

    initial begin
        lat_min = 0;
        lat_max = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_acc();
        test_misalign();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core. Owns the program counter and issues word fetches to instruction memory over a valid/ready request plus valid-only response interface.
- Buffers returned words in a 2-entry queue and presents {instr, pc, pc+4} to decode over valid/ready.
- instr drives the decoder and the immediate sign-extension unit (Inst[31:0]).
- Branch/jump redirects flush all in-flight and buffered work.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0013, value shown on instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  imem accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address ([1:0] always 00)
- imem_rsp_valid  in  1  response word valid (one per accepted request, ≥1 cycle after acceptance, in order)
- imem_rsp_data  in  32  response instruction word
- redirect_valid  in  1  taken branch/jump, one-cycle pulse
- redirect_pc  in  32  redirect target
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction word (NOP_WORD when empty)
- instr_pc  out  32  PC of head (0 when empty)
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32
- misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 00

Behaviour:
- Reset (async assert; sync release sampled at clk):
  - fetch_pc = RESET_PC; state = IDLE; queue empty.
  - Outputs: imem_req_valid = 0, instr_valid = 0, instr = NOP_WORD, instr_pc = 0, misalign_err = 0.
  - Reset mid-request: the pending response is lost; imem is reset together with this block.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE -> REQ: unconditional after one cycle.
  - REQ:
    - imem_req_valid = 1 only if queue_count + inflight < 2. Credit check: inflight is 1 in WAIT/DROP and 0 in REQ.
    - imem_req_addr = fetch_pc.
    - On valid&ready: go to WAIT and set fetch_pc += 4.
    - The address may change before acceptance; imem must tolerate this.
  - WAIT:
    - On imem_rsp_valid: push {data, pc_of_request} and go to REQ. Request pc is held in a register.
  - DROP:
    - On imem_rsp_valid: discard the word and go to REQ.
- Throughput: one outstanding request, so the best case is one instruction per 2 cycles with 1-cycle imem latency.
- Timing: a response in cycle N becomes visible on instr_valid in cycle N+1 (registered queue).
- Queue: 2 entries, FIFO order.
  - Push (rsp accepted in WAIT) and pop (instr_valid & instr_ready) may occur in the same cycle; count is unchanged.
  - The credit check guarantees no overflow. A push when full is impossible; the bench asserts on it.
  - Pop while empty is ignored.
- Redirect (redirect_valid = 1), highest priority:
  - fetch_pc <= {redirect_pc[31:2], 2'b00}. misalign_err pulses the next cycle if redirect_pc[1:0] != 0.
  - The queue flushes: instr_valid = 0 next cycle. A pop in the same cycle still counts as consumed by decode; it is not replayed.
  - In REQ without acceptance: stay in REQ; the new address appears next cycle.
  - In REQ with acceptance the same cycle: go to DROP. The request used the old address; fetch_pc = redirect target, not +4.
  - In WAIT without rsp: go to DROP.
  - In WAIT with rsp the same cycle: discard the rsp and go to REQ.
  - In DROP: stay in DROP (or go to REQ if rsp arrives); fetch_pc is updated.
  - In IDLE: fetch_pc is updated and the state proceeds to REQ.
- PC arithmetic: 32-bit wrap. 0xFFFF_FFFC + 4 = 0x0000_0000.

Test Plan:
- Reset, imem 1-cycle latency returning mem[a] = a|0x13, instr_ready = 1:
  - Req addrs are 0x0, 0x4, 0x8 on cycles 1, 3, 5.
  - instr/pc pairs are (0x13, 0x0), (0x17, 0x4); pc_plus4 = 0x4, 0x8.
- Backpressure: instr_ready = 0:
  - Exactly 2 responses queue up; imem_req_valid stays 0 afterwards.
  - Release instr_ready: FIFO order is kept and requests resume at 0x8.
- Redirect to 0x100 while in WAIT for 0x8:
  - The 0x8 response is dropped; the next request is 0x100.
  - The queue is empty the next cycle; the first delivered pc is 0x100.
- Redirect in the same cycle as a REQ handshake for 0xC:
  - DROP absorbs the 0xC response; the next request is 0x200.
- Redirect to 0x202: the next request is 0x200, and misalign_err is high for exactly 1 cycle.
- PC wrap and async reset:
  - Redirect to 0xFFFF_FFFC: pc_plus4 = 0x0 and the next request is 0x0.
  - Assert rst mid-WAIT: outputs return to reset values immediately without a clock edge.
